sample_input: RTL and testbench
===============================

# sample_input

Reads one pair of samples from the external dual-channel ADC over a 3-wire SPI link. It is the capture-side counterpart of the DAC sample output path. On each accepted start it clocks one 24-bit frame for channel A (left), then one for channel B (right). It removes the same DC offset the output path adds, and presents both results as 32-bit samples with a one-cycle valid strobe. The block sits between the ADC pins and the sample-rate logic that reads control and audio inputs.

## Interface
- SAMPLE_OFFSET, 32'h20500, offset subtracted from each scaled raw sample
- READ_CHANNEL_A, 8'b00110001, command byte sent on MOSI for the left/A frame
- READ_CHANNEL_B, 8'b00110010, command byte sent on MOSI for the right/B frame
- CLOCK_DIV, 4, system clocks per SPI clock half-period; legal range 1..255
- i_Clock  in  1  system clock; single clock domain
- i_Reset  in  1  synchronous, active-high reset
- i_Start  in  1  request a read; accepted only when o_Ready=1
- i_SPI_Data  in  1  MISO from the ADC
- o_SPI_CS  out  1  chip select, active low; reset 1
- o_SPI_Clock  out  1  SPI clock, mode 0 (idle low); reset 0
- o_SPI_Data  out  1  MOSI; reset 0
- o_Sample_L  out  32  converted channel A sample; reset 0
- o_Sample_R  out  32  converted channel B sample; reset 0
- o_Valid  out  1  one-cycle pulse when both samples update; reset 0
- o_Ready  out  1  idle and able to accept i_Start; reset 1

## Operation
- States: IDLE -> FRAME_L -> GAP -> FRAME_R -> DONE -> IDLE.
- IDLE: o_Ready=1, CS high, SCLK low. If i_Start=1, the start is accepted at that edge (T0).
- Frame: 24 bits, MSB first. MOSI word is {command byte, 16'h0000}. Each bit has a low half-period (CLOCK_DIV cycles) then a high half-period (CLOCK_DIV cycles).
- MOSI changes only while SCLK is low.
- MISO is sampled on the last cycle of each high half-period into a 24-bit shift register.
- GAP: CS high and SCLK low for 2*CLOCK_DIV cycles between frames.
- Conversion of each frame: raw = rx[15:0]; sample = {14'b0, raw, 2'b00} - SAMPLE_OFFSET. This is 32-bit modulo arithmetic. rx[23:16] is ignored.
- DONE: o_Sample_L and o_Sample_R update together and o_Valid pulses. The block returns to IDLE in the same cycle.
- o_Sample_L and o_Sample_R hold their values between o_Valid pulses.
- i_Start while o_Ready=0 is ignored and not queued.

## Timing
- T0 = the edge where i_Start && o_Ready is sampled. Let D = CLOCK_DIV.
- T0+1: CS low, MOSI = READ_CHANNEL_A[7], o_Ready=0.
- Left frame: T0+1 .. T0+48D. SCLK first rises at T0+1+D.
- Gap: T0+48D+1 .. T0+50D.
- Right frame: T0+50D+1 .. T0+98D.
- T0+98D+1: CS high, o_Valid=1, new samples visible, o_Ready=1.
- With D=4: o_Valid at T0+393.
- A start asserted on the o_Valid cycle is accepted; the next frame's CS falls one cycle later.
- Reset mid-operation takes effect at the next edge: all outputs return to their reset values and any partial frame is discarded.

## Configuration
- SAMPLE_INPUT_AVERAGE_EN
- Defined: each channel outputs (conv + prev_conv) >>> 1.
  - conv is the newly converted sample; prev_conv is the previous conversion for that channel.
  - Both are treated as 32-bit signed; the sum is computed at 33 bits; >>> is an arithmetic shift.
  - prev_conv resets to 0.
- Undefined: outputs equal conv directly. No extra registers.
- Latency is identical in both builds.

## Test plan
- Reset release, D=4: CS=1, SCLK=0, MOSI=0, samples=0, o_Valid=0, o_Ready=1. Holding i_Start low for 1000 cycles produces no SCLK edges.
- Start with the ADC model returning raw 0x8141 on A and 0x0000 on B: MOSI carries 0x31 then 0x32. Exactly 24 rising SCLK edges per frame. o_Valid at T0+393 with L=0x00000004, R=0xFFFDFB00.
- i_Start held high continuously: o_Valid pulses every 393 cycles. CS gap is 8 cycles inside each read and exactly 1 cycle between reads. Extra starts during busy periods are ignored.
- Reset asserted at T0+100: CS high and SCLK low on the next cycle. No o_Valid is produced and the previous samples are cleared. A new start completes normally.
- CLOCK_DIV=1: o_Valid at T0+99 and SCLK toggles every cycle. Captured values must match the ADC model bit-exactly.
- SAMPLE_INPUT_AVERAGE_EN defined, A raw 0x8141 on two consecutive reads: first L=0x00000002, second L=0x00000004.

Source files
------------

// File: rtl/sample_input.sv
// sample_input: captures one left/right sample pair from a dual-channel ADC
// over a 3-wire SPI link and removes the DC offset the output path adds.
//
// Ports:
//   i_Clock      system clock (single domain)
//   i_Reset      synchronous, active-high reset
//   i_Start      request a read; taken only while o_Ready=1
//   i_SPI_Data   MISO from the ADC
//   o_SPI_CS     chip select, active low
//   o_SPI_Clock  SPI clock, mode 0 (idle low)
//   o_SPI_Data   MOSI
//   o_Sample_L   converted channel A sample
//   o_Sample_R   converted channel B sample
//   o_Valid      one-cycle pulse when both samples update
//   o_Ready      idle and able to accept i_Start
//
// Build option: define SAMPLE_INPUT_AVERAGE_EN to output the mean of the
// new and previous conversion of each channel.
`timescale 1ns/1ps

module sample_input #(
  parameter logic [31:0] SAMPLE_OFFSET  = 32'h20500,
  parameter logic [7:0]  READ_CHANNEL_A = 8'b00110001,
  parameter logic [7:0]  READ_CHANNEL_B = 8'b00110010,
  parameter int unsigned CLOCK_DIV      = 4
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Start,
  input  logic        i_SPI_Data,
  output logic        o_SPI_CS,
  output logic        o_SPI_Clock,
  output logic        o_SPI_Data,
  output logic [31:0] o_Sample_L,
  output logic [31:0] o_Sample_R,
  output logic        o_Valid,
  output logic        o_Ready
);

  typedef enum logic [2:0] {
    IDLE,
    FRAME_L,
    GAP,
    FRAME_R,
    DONE
  } state_t;

  localparam logic [8:0] HALF_END =
    9'(CLOCK_DIV - 1);
  localparam logic [8:0] GAP_END =
    9'(2 * CLOCK_DIV - 1);
  localparam logic [4:0] LAST_BIT = 5'd23;

  state_t      state;
  state_t      state_n;
  logic [8:0]  cnt;
  logic [8:0]  cnt_n;
  logic [4:0]  bit_idx;
  logic [4:0]  bit_n;
  logic        sclk;
  logic        sclk_n;
  logic        cs;
  logic        cs_n;
  logic [23:0] tx;
  logic [23:0] tx_n;
  // Only the low 16 received bits are ever used, so the receive
  // shifter keeps just those; the command echo byte falls off the top.
  logic [15:0] rx;
  logic [15:0] rx_n;
  logic [31:0] hold_l;
  logic [31:0] hold_l_n;
  logic [31:0] samp_l;
  logic [31:0] samp_l_n;
  logic [31:0] samp_r;
  logic [31:0] samp_r_n;
  logic [31:0] conv;
  logic        last;

`ifdef SAMPLE_INPUT_AVERAGE_EN
  logic [31:0] prev_l;
  logic [31:0] prev_l_n;
  logic [31:0] prev_r;
  logic [31:0] prev_r_n;
`endif

  function automatic logic [31:0] to_sample(
    input logic [15:0] raw
  );
    return {14'b0, raw, 2'b00} - SAMPLE_OFFSET;
  endfunction

`ifdef SAMPLE_INPUT_AVERAGE_EN
  // Signed mean of two samples; the 33-bit sum cannot overflow and
  // dropping its LSB is an arithmetic shift right by one.
  function automatic logic [31:0] mean2(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [32:0] sum;
    sum = {a[31], a} + {b[31], b};
    return sum[32:1];
  endfunction
`endif

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sclk    <= 1'b0;
      cs      <= 1'b1;
      tx      <= '0;
      rx      <= '0;
      hold_l  <= '0;
      samp_l  <= '0;
      samp_r  <= '0;
`ifdef SAMPLE_INPUT_AVERAGE_EN
      prev_l  <= '0;
      prev_r  <= '0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      sclk    <= sclk_n;
      cs      <= cs_n;
      tx      <= tx_n;
      rx      <= rx_n;
      hold_l  <= hold_l_n;
      samp_l  <= samp_l_n;
      samp_r  <= samp_r_n;
`ifdef SAMPLE_INPUT_AVERAGE_EN
      prev_l  <= prev_l_n;
      prev_r  <= prev_r_n;
`endif
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bit_n    = bit_idx;
    sclk_n   = sclk;
    cs_n     = cs;
    tx_n     = tx;
    rx_n     = rx;
    hold_l_n = hold_l;
    samp_l_n = samp_l;
    samp_r_n = samp_r;
    conv     = '0;
    last     = 1'b0;
`ifdef SAMPLE_INPUT_AVERAGE_EN
    prev_l_n = prev_l;
    prev_r_n = prev_r;
`endif
    unique case (state)
      // DONE also accepts a start so back-to-back
      // reads leave a single CS-high cycle.
      IDLE, DONE: begin
        state_n = IDLE;
        if (i_Start) begin
          state_n = FRAME_L;
          cs_n    = 1'b0;
          sclk_n  = 1'b0;
          cnt_n   = '0;
          bit_n   = '0;
          tx_n    = {READ_CHANNEL_A, 16'h0000};
        end
      end
      FRAME_L, FRAME_R: begin
        if (cnt == HALF_END) begin
          cnt_n  = '0;
          sclk_n = ~sclk;
          // End of a high half: capture MISO, then
          // advance MOSI as SCLK drops.
          if (sclk) begin
            rx_n = {rx[14:0], i_SPI_Data};
            if (bit_idx == LAST_BIT) begin
              last = 1'b1;
            end else begin
              bit_n = bit_idx + 5'd1;
              tx_n  = {tx[22:0], 1'b0};
            end
          end
        end else begin
          cnt_n = cnt + 9'd1;
        end
        if (last) begin
          cs_n   = 1'b1;
          sclk_n = 1'b0;
          tx_n   = '0;
          bit_n  = '0;
          cnt_n  = '0;
          conv   = to_sample(rx_n);
          if (state == FRAME_L) begin
            state_n  = GAP;
            hold_l_n = conv;
          end else begin
            state_n = DONE;
`ifdef SAMPLE_INPUT_AVERAGE_EN
            samp_l_n = mean2(hold_l, prev_l);
            samp_r_n = mean2(conv, prev_r);
            prev_l_n = hold_l;
            prev_r_n = conv;
`else
            samp_l_n = hold_l;
            samp_r_n = conv;
`endif
          end
        end
      end
      GAP: begin
        if (cnt == GAP_END) begin
          state_n = FRAME_R;
          cs_n    = 1'b0;
          cnt_n   = '0;
          tx_n    = {READ_CHANNEL_B, 16'h0000};
        end else begin
          cnt_n = cnt + 9'd1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign o_SPI_CS    = cs;
  assign o_SPI_Clock = sclk;
  assign o_SPI_Data  = tx[23];
  assign o_Sample_L  = samp_l;
  assign o_Sample_R  = samp_r;
  assign o_Valid     = (state == DONE);
  assign o_Ready     = (state == IDLE) ||
                       (state == DONE);

endmodule

// File: tb/tb_sample_input.sv
// tb_sample_input: drives two sample_input instances (CLOCK_DIV 4 and 1)
// against a behavioural dual-channel ADC model and a sample scoreboard.
`timescale 1ns/1ps

module tb_sample_input;

  localparam logic [31:0] OFFSET = 32'h20500;
  localparam logic [7:0]  CMD_A  = 8'h31;
  localparam logic [7:0]  CMD_B  = 8'h32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst;
  logic [1:0]       start;
  logic [1:0]       miso;
  logic [1:0]       cs;
  logic [1:0]       sclk;
  logic [1:0]       mosi;
  logic [1:0]       valid;
  logic [1:0]       ready;
  logic [1:0][31:0] samp_l;
  logic [1:0][31:0] samp_r;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sample_input #(
      .CLOCK_DIV(g == 0 ? 4 : 1)
    ) u_dut (
      .i_Clock    (clk),
      .i_Reset    (rst[g]),
      .i_Start    (start[g]),
      .i_SPI_Data (miso[g]),
      .o_SPI_CS   (cs[g]),
      .o_SPI_Clock(sclk[g]),
      .o_SPI_Data (mosi[g]),
      .o_Sample_L (samp_l[g]),
      .o_Sample_R (samp_r[g]),
      .o_Valid    (valid[g]),
      .o_Ready    (ready[g])
    );
  end

  int total = 0;
  int bad   = 0;

  // ADC model: watches the pins once per cycle, behaves as a mode-0 slave.
  logic [1:0][15:0] raw_a;
  logic [1:0][15:0] raw_b;
  logic [23:0]      word [2];
  logic [23:0]      mcap [2];
  logic [7:0]       fr_cmd [2][2];
  int               fr_rises [2][2];
  int               fr_hic [2][2];
  int               rises [2];
  int               hic [2];
  int               fidx [2];
  int               fdone [2];
  int               sclk_edges [2];
  int               mosi_bad [2];
  logic [1:0]       pcs;
  logic [1:0]       psclk;
  logic [1:0]       pmosi;
  logic [7:0]       hb;

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst[g]) begin
        fidx[g] = 0;
        miso[g] = 1'b0;
      end else begin
        if (pcs[g] && !cs[g]) begin
          hb = 8'($urandom);
          word[g] = (fidx[g] % 2 == 1) ? {hb, raw_b[g]}
                                      : {hb, raw_a[g]};
          miso[g]  = word[g][23];
          rises[g] = 0;
          hic[g]   = 0;
          mcap[g]  = '0;
        end
        if (!cs[g]) begin
          if (sclk[g]) hic[g]++;
          if (!psclk[g] && sclk[g]) begin
            rises[g]++;
            mcap[g] = {mcap[g][22:0], mosi[g]};
          end
          if (psclk[g] && !sclk[g]) begin
            word[g] = {word[g][22:0], 1'b0};
            miso[g] = word[g][23];
          end
          if (sclk[g] && !pcs[g] && mosi[g] !== pmosi[g])
            mosi_bad[g]++;
        end
        if (!pcs[g] && cs[g]) begin
          fr_rises[g][fidx[g] % 2] = rises[g];
          fr_hic[g][fidx[g] % 2]   = hic[g];
          fr_cmd[g][fidx[g] % 2]   = mcap[g][23:16];
          fidx[g]++;
          fdone[g]++;
        end
        if (sclk[g] !== psclk[g]) sclk_edges[g]++;
      end
      pcs[g]   = cs[g];
      psclk[g] = sclk[g];
      pmosi[g] = mosi[g];
    end
  end

  // Scoreboard: sample = 4*raw - offset (mod 2^32), optional signed mean.
  logic [31:0] prev_l [2];
  logic [31:0] prev_r [2];

  function automatic logic [31:0] conv_of(input logic [15:0] raw);
    longint v;
    v = longint'(raw) * 4 - longint'(OFFSET);
    return 32'(v);
  endfunction

  function automatic logic [31:0] avg_of(
    input logic [31:0] a,
    input logic [31:0] b
  );
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
    return 32'((s - (s & 1)) / 2);
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input int          g,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h",
             tag, g, obs, exp);
    end
  endtask

  task automatic chk_samples(input int g);
    logic [31:0] cl;
    logic [31:0] cr;
    logic [31:0] el;
    logic [31:0] er;
    cl = conv_of(raw_a[g]);
    cr = conv_of(raw_b[g]);
`ifdef SAMPLE_INPUT_AVERAGE_EN
    el = avg_of(cl, prev_l[g]);
    er = avg_of(cr, prev_r[g]);
    prev_l[g] = cl;
    prev_r[g] = cr;
`else
    el = cl;
    er = cr;
`endif
    chk("sample_l", g, samp_l[g], el);
    chk("sample_r", g, samp_r[g], er);
  endtask

  task automatic do_read(input int g);
    int d;
    int lat;
    int f0;
    d  = (g == 0) ? 4 : 1;
    f0 = fdone[g];
    start[g] = 1'b1;
    step();
    start[g] = 1'b0;
    chk("t1_cs", g, cs[g], 0);
    chk("t1_ready", g, ready[g], 0);
    chk("t1_mosi", g, mosi[g], CMD_A[7]);
    lat = 1;
    while (valid[g] !== 1'b1 && lat < 2000) begin
      step();
      lat++;
    end
    chk("latency", g, lat, 98 * d + 1);
    chk_samples(g);
    chk("done_cs", g, cs[g], 1);
    chk("done_ready", g, ready[g], 1);
    chk("frames", g, fdone[g] - f0, 2);
    chk("rises_a", g, fr_rises[g][0], 24);
    chk("rises_b", g, fr_rises[g][1], 24);
    chk("cmd_a", g, fr_cmd[g][0], CMD_A);
    chk("cmd_b", g, fr_cmd[g][1], CMD_B);
    chk("hi_cyc_a", g, fr_hic[g][0], 24 * d);
    step();
    chk("valid_pulse", g, valid[g], 0);
  endtask

  task automatic do_reset(input int g);
    rst[g] = 1'b1;
    step();
    step();
    rst[g] = 1'b0;
    prev_l[g] = '0;
    prev_r[g] = '0;
  endtask

  initial begin
    int e0;
    int nv;
    int cyc;
    int cshi;
    int vcyc [3];
    int vcs [3];
    rst   = 2'b11;
    start = 2'b00;
    raw_a = '0;
    raw_b = '0;
    for (int g = 0; g < 2; g++) begin
      prev_l[g] = '0;
      prev_r[g] = '0;
    end
    repeat (3) step();
    rst = 2'b00;
    step();

    for (int g = 0; g < 2; g++) begin
      chk("rst_cs", g, cs[g], 1);
      chk("rst_sclk", g, sclk[g], 0);
      chk("rst_mosi", g, mosi[g], 0);
      chk("rst_l", g, samp_l[g], 0);
      chk("rst_r", g, samp_r[g], 0);
      chk("rst_valid", g, valid[g], 0);
      chk("rst_ready", g, ready[g], 1);
    end

    e0 = sclk_edges[0];
    repeat (1000) step();
    chk("idle_sclk", 0, sclk_edges[0] - e0, 0);

    raw_a[0] = 16'h8141;
    raw_b[0] = 16'h0000;
    do_read(0);
`ifdef SAMPLE_INPUT_AVERAGE_EN
    chk("avg_first_l", 0, samp_l[0], 32'h00000002);
    do_read(0);
    chk("avg_second_l", 0, samp_l[0], 32'h00000004);
`else
    chk("fixed_l", 0, samp_l[0], 32'h00000004);
    chk("fixed_r", 0, samp_r[0], 32'hFFFDFB00);
    do_read(0);
`endif
    chk("hold_l", 0, samp_l[0], samp_l[0] === 32'hx ? 0 : conv_of(16'h8141));

    for (int i = 0; i < 2; i++) begin
      raw_a[0] = 16'($urandom);
      raw_b[0] = 16'($urandom);
      do_read(0);
    end

    raw_a[0] = 16'($urandom);
    raw_b[0] = 16'($urandom);
    start[0] = 1'b1;
    nv   = 0;
    cyc  = 0;
    cshi = 0;
    while (nv < 3 && cyc < 2000) begin
      step();
      cyc++;
      if (cs[0]) cshi++;
      if (valid[0] === 1'b1) begin
        vcyc[nv] = cyc;
        vcs[nv]  = cshi;
        cshi     = 0;
        chk_samples(0);
        nv++;
        if (nv == 3) start[0] = 1'b0;
      end
    end
    start[0] = 1'b0;
    chk("cont_valids", 0, nv, 3);
    chk("cont_first", 0, vcyc[0], 393);
    chk("cont_period1", 0, vcyc[1] - vcyc[0], 393);
    chk("cont_period2", 0, vcyc[2] - vcyc[1], 393);
    chk("cont_cs_hi1", 0, vcs[1], 9);
    chk("cont_cs_hi2", 0, vcs[2], 9);
    step();
    chk("cont_stop", 0, ready[0], 1);

    raw_a[0] = 16'($urandom);
    raw_b[0] = 16'($urandom);
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    repeat (99) step();
    rst[0] = 1'b1;
    step();
    chk("mid_rst_cs", 0, cs[0], 1);
    chk("mid_rst_sclk", 0, sclk[0], 0);
    chk("mid_rst_l", 0, samp_l[0], 0);
    chk("mid_rst_r", 0, samp_r[0], 0);
    step();
    rst[0] = 1'b0;
    prev_l[0] = '0;
    prev_r[0] = '0;
    nv = 0;
    repeat (500) begin
      step();
      if (valid[0] !== 1'b0) nv++;
    end
    chk("mid_rst_novalid", 0, nv, 0);
    do_read(0);

    for (int i = 0; i < 3; i++) begin
      raw_a[1] = 16'($urandom);
      raw_b[1] = 16'($urandom);
      do_read(1);
    end
    do_reset(1);
    raw_a[1] = 16'hFFFF;
    raw_b[1] = 16'h8141;
    do_read(1);

    chk("mosi_stable", 0, mosi_bad[0], 0);
    chk("mosi_stable", 1, mosi_bad[1], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
